// File: rtl/mac_pkg.sv
// Shared control type and pipeline depth for the multiply-add/subtract-accumulate block.
package mac_pkg;

   typedef struct packed {
      logic is_signed;
      logic addsub;
      logic load_c;
      logic cin;
   } mac_ctrl_t;

   localparam int MAC_LATENCY = 3;

endpackage

// File: rtl/mac_addsub_pipe_if.sv
// Operand/control inputs and result outputs of mac_addsub_pipe; ovf exists only when MAC_OVF_EN is defined.
interface mac_addsub_pipe_if #(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int C_W = 54,
   parameter int Z_W = 54
);
   logic           in_valid;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic [C_W-1:0] c;
   logic           is_signed;
   logic           addsub;
   logic           load_c;
   logic           cin;
   logic           flush;
   logic           out_valid;
   logic [Z_W-1:0] z;
`ifdef MAC_OVF_EN
   logic           ovf;
`endif

   modport master (
      output in_valid, a, b, c, is_signed, addsub, load_c, cin, flush,
      input  out_valid, z
`ifdef MAC_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, c, is_signed, addsub, load_c, cin, flush,
      output out_valid, z
`ifdef MAC_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/mac_accum.sv
// Final stage: base select, z <= base +/- P + cin, one-cycle feedback so back-to-back accumulates never stall.
// Sticky ovf (MAC_OVF_EN) tracks results not representable in Z_W; no backpressure.
module mac_accum
   import mac_pkg::*;
#(
   parameter int Z_W = 54
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           vld,
   input  mac_ctrl_t      ctrl,
   input  logic [Z_W-1:0] p,
   input  logic [Z_W-1:0] c,
   output logic           out_valid,
   output logic [Z_W-1:0] z
`ifdef MAC_OVF_EN
   ,
   output logic           ovf
`endif
);

   logic [Z_W-1:0] base;
   logic [Z_W-1:0] sum;

   assign base = ctrl.load_c ? c : z;
   assign sum  = ctrl.addsub ? (base - p + Z_W'(ctrl.cin))
                             : (base + p + Z_W'(ctrl.cin));

   // Bubbles leave z untouched; flush returns the accumulator to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         z         <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         z         <= '0;
      end else begin
         out_valid <= vld;
         if (vld) begin
            z <= sum;
         end
      end
   end

`ifdef MAC_OVF_EN
   // Two guard bits hold the exact result of base +/- P + cin for either signedness.
   localparam int W_W = Z_W + 2;

   logic [W_W-1:0] base_w;
   logic [W_W-1:0] p_w;
   logic [W_W-1:0] res_w;
   logic           ovf_now;

   assign base_w = ctrl.is_signed ? W_W'($signed(base)) : W_W'(base);
   assign p_w    = ctrl.is_signed ? W_W'($signed(p))    : W_W'(p);
   assign res_w  = ctrl.addsub ? (base_w - p_w + W_W'(ctrl.cin))
                               : (base_w + p_w + W_W'(ctrl.cin));

   always_comb begin
      ovf_now = 1'b0;
      if (ctrl.is_signed) begin
         ovf_now = !((&res_w[W_W-1:Z_W-1]) || !(|res_w[W_W-1:Z_W-1]));
      end else begin
         ovf_now = |res_w[W_W-1:Z_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (flush) begin
         ovf <= 1'b0;
      end else if (vld && ovf_now) begin
         ovf <= 1'b1;
      end
   end
`else
   logic unused_sign;
   assign unused_sign = ctrl.is_signed;
`endif

endmodule

// File: rtl/mac_addsub_pipe.sv
// Pipelined Z = base +/- A*B + CIN (base = C or previous Z); latency 3, one transaction per cycle, no backpressure.
// Define MAC_OVF_EN to add the sticky ovf output; flush clears the pipe and accumulator synchronously.
module mac_addsub_pipe
   import mac_pkg::*;
#(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int C_W = 54,
   parameter int Z_W = 54
) (
   input logic              clk,
   input logic              rst_n,
   mac_addsub_pipe_if.slave bus
);

   localparam int P_W = A_W + B_W;

   generate
      if (Z_W < P_W || Z_W < C_W) begin : g_bad_width
         $error("mac_addsub_pipe: Z_W must be at least A_W+B_W and at least C_W");
      end
   endgenerate

   // S1: operand and control capture.
   logic           v1;
   logic [A_W-1:0] a1;
   logic [B_W-1:0] b1;
   logic [C_W-1:0] c1;
   mac_ctrl_t      ctrl1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         a1    <= '0;
         b1    <= '0;
         c1    <= '0;
         ctrl1 <= '0;
      end else if (bus.flush) begin
         v1 <= 1'b0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            a1    <= bus.a;
            b1    <= bus.b;
            c1    <= bus.c;
            ctrl1 <= '{is_signed: bus.is_signed, addsub: bus.addsub,
                       load_c: bus.load_c, cin: bus.cin};
         end
      end
   end

   // S2: full-width product, then extension of P and C to Z_W by operand signedness.
   logic        [P_W-1:0] prod_u;
   logic signed [P_W-1:0] prod_s;
   logic        [Z_W-1:0] p_ext;
   logic        [Z_W-1:0] c_ext;

   assign prod_u = P_W'(a1) * P_W'(b1);
   assign prod_s = P_W'($signed(a1)) * P_W'($signed(b1));
   assign p_ext  = ctrl1.is_signed ? Z_W'(prod_s)      : Z_W'(prod_u);
   assign c_ext  = ctrl1.is_signed ? Z_W'($signed(c1)) : Z_W'(c1);

   logic           v2;
   logic [Z_W-1:0] p2;
   logic [Z_W-1:0] c2;
   mac_ctrl_t      ctrl2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         p2    <= '0;
         c2    <= '0;
         ctrl2 <= '0;
      end else if (bus.flush) begin
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            p2    <= p_ext;
            c2    <= c_ext;
            ctrl2 <= ctrl1;
         end
      end
   end

   // S3: accumulate stage.
   mac_accum #(
      .Z_W (Z_W)
   ) u_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .vld       (v2),
      .ctrl      (ctrl2),
      .p         (p2),
      .c         (c2),
      .out_valid (bus.out_valid),
      .z         (bus.z)
`ifdef MAC_OVF_EN
      ,
      .ovf       (bus.ovf)
`endif
   );

endmodule

// File: tb/tb_mac_addsub_pipe.sv
// Directed and random checks of mac_addsub_pipe with a latency-aware result scoreboard.
module tb_mac_addsub_pipe;
   import mac_pkg::*;

   localparam int A_W = 18;
   localparam int B_W = 18;
   localparam int C_W = 54;
   localparam int Z_W = 54;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mac_addsub_pipe_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .Z_W(Z_W)) mac_if ();

   mac_addsub_pipe #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .Z_W(Z_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mac_if)
   );

   typedef struct {
      logic [Z_W-1:0] z;
      int             due;
   } exp_t;

   exp_t           exp_q[$];
   int             vectors     = 0;
   int             miscompares = 0;
   int             cyc         = 0;
   logic [Z_W-1:0] hold_z      = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Every output cycle pops one expectation; every idle cycle checks the accumulator holds.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (mac_if.out_valid === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_out: observed out_valid=1 z=%0h, required no output", mac_if.z);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               vectors++;
               assert (mac_if.z === e.z) else begin
                  miscompares++;
                  $error("FAIL result_z: observed %0h required %0h", mac_if.z, e.z);
               end
               vectors++;
               assert (cyc === e.due) else begin
                  miscompares++;
                  $error("FAIL latency: observed output cycle %0d required %0d", cyc, e.due);
               end
               hold_z = e.z;
            end
         end else begin
            vectors++;
            assert (mac_if.out_valid === 1'b0 && mac_if.z === hold_z) else begin
               miscompares++;
               $error("FAIL idle_hold: observed out_valid=%b z=%0h required 0/%0h",
                      mac_if.out_valid, mac_if.z, hold_z);
            end
         end
      end
   end

   function automatic logic [Z_W-1:0] ref_mac(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input logic [C_W-1:0] c, input logic sgn,
                                               input logic sub, input logic ci);
      logic signed [Z_W-1:0] sa, sbv;
      logic [Z_W-1:0] p, ce;
      if (sgn) begin
         sa  = Z_W'($signed(a));
         sbv = Z_W'($signed(b));
         p   = sa * sbv;
         ce  = Z_W'($signed(c));
      end else begin
         p  = Z_W'(a) * Z_W'(b);
         ce = Z_W'(c);
      end
      return sub ? (ce - p + Z_W'(ci)) : (ce + p + Z_W'(ci));
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic [C_W-1:0] c,
                       input logic sgn, input logic sub, input logic ld, input logic ci,
                       input logic [Z_W-1:0] exp_z);
      exp_t e;
      mac_if.in_valid  = 1'b1;
      mac_if.a         = a;
      mac_if.b         = b;
      mac_if.c         = c;
      mac_if.is_signed = sgn;
      mac_if.addsub    = sub;
      mac_if.load_c    = ld;
      mac_if.cin       = ci;
      e.z   = exp_z;
      e.due = cyc + MAC_LATENCY;
      exp_q.push_back(e);
      tick(1);
      mac_if.in_valid = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
      end
   endtask

   initial begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      logic [C_W-1:0] rc;
      logic           rs, rsub, rci;

      mac_if.in_valid  = 1'b0;
      mac_if.a         = '0;
      mac_if.b         = '0;
      mac_if.c         = '0;
      mac_if.is_signed = 1'b0;
      mac_if.addsub    = 1'b0;
      mac_if.load_c    = 1'b0;
      mac_if.cin       = 1'b0;
      mac_if.flush     = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_out_valid", 64'(mac_if.out_valid), 64'd0);
      check("reset_z", 64'(mac_if.z), 64'd0);
`ifdef MAC_OVF_EN
      check("reset_ovf", 64'(mac_if.ovf), 64'd0);
`endif
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Directed single transactions.
      send(18'd3, 18'd5, 54'd100, 1'b0, 1'b0, 1'b1, 1'b1, 54'd116);
      send(18'h3FFFE, 18'd7, 54'd0, 1'b1, 1'b0, 1'b1, 1'b0, 54'h3F_FFFF_FFFF_FFF2);
      send(18'd10, 18'd10, 54'd1000, 1'b0, 1'b1, 1'b1, 1'b0, 54'd900);
      tick(4);

      for (int i = 0; i < 6; i++) begin
         ra   = A_W'($urandom);
         rb   = B_W'($urandom);
         rc   = C_W'({$urandom, $urandom});
         rs   = 1'($urandom);
         rsub = 1'($urandom);
         rci  = 1'($urandom);
         send(ra, rb, rc, rs, rsub, 1'b1, rci, ref_mac(ra, rb, rc, rs, rsub, rci));
      end
      tick(4);

      // Back-to-back accumulation, then the same with bubbles.
      send(18'd2, 18'd3, 54'd0, 1'b0, 1'b0, 1'b1, 1'b0, 54'd6);
      send(18'd2, 18'd3, 54'd777, 1'b0, 1'b0, 1'b0, 1'b0, 54'd12);
      send(18'd2, 18'd3, 54'd777, 1'b0, 1'b0, 1'b0, 1'b0, 54'd18);
      send(18'd2, 18'd3, 54'd777, 1'b0, 1'b0, 1'b0, 1'b0, 54'd24);
      tick(4);
      send(18'd2, 18'd3, 54'd0, 1'b0, 1'b0, 1'b1, 1'b0, 54'd6);
      tick(1);
      send(18'd2, 18'd3, 54'd0, 1'b0, 1'b0, 1'b0, 1'b0, 54'd12);
      tick(1);
      send(18'd2, 18'd3, 54'd0, 1'b0, 1'b0, 1'b0, 1'b0, 54'd18);
      tick(1);
      send(18'd2, 18'd3, 54'd0, 1'b0, 1'b0, 1'b0, 1'b0, 54'd24);
      tick(5);

      // Reset pulsed with two transactions in flight: asynchronous clear, nothing emerges.
      send(18'd4, 18'd4, 54'd1, 1'b0, 1'b0, 1'b1, 1'b0, 54'd17);
      send(18'd4, 18'd4, 54'd2, 1'b0, 1'b0, 1'b1, 1'b0, 54'd18);
      rst_n = 1'b0;
      exp_q.delete();
      hold_z = '0;
      #1;
      check("async_reset_z", 64'(mac_if.z), 64'd0);
      check("async_reset_out_valid", 64'(mac_if.out_valid), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      send(18'd2, 18'd3, 54'd999, 1'b0, 1'b0, 1'b0, 1'b0, 54'd6);
      tick(4);

      // Flush with two in flight plus a dropped transaction in the flush cycle.
      send(18'd7, 18'd7, 54'd1, 1'b0, 1'b0, 1'b1, 1'b0, 54'd50);
      send(18'd7, 18'd7, 54'd2, 1'b0, 1'b0, 1'b1, 1'b0, 54'd51);
      mac_if.flush    = 1'b1;
      mac_if.in_valid = 1'b1;
      mac_if.load_c   = 1'b1;
      mac_if.c        = 54'd123;
      tick(1);
      exp_q.delete();
      hold_z = '0;
      mac_if.flush    = 1'b0;
      mac_if.in_valid = 1'b0;
      tick(5);
      @(negedge clk);
      check("flush_z", 64'(mac_if.z), 64'd0);
      tick(1);
      send(18'd2, 18'd3, 54'd999, 1'b0, 1'b0, 1'b0, 1'b1, 54'd7);
      tick(4);

`ifdef MAC_OVF_EN
      send(18'd1, 18'd1, {C_W{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0, 54'd0);
      tick(4);
      check("ovf_set", 64'(mac_if.ovf), 64'd1);
      send(18'd1, 18'd1, 54'd5, 1'b0, 1'b0, 1'b1, 1'b0, 54'd6);
      tick(4);
      check("ovf_sticky", 64'(mac_if.ovf), 64'd1);
      mac_if.flush = 1'b1;
      tick(1);
      mac_if.flush = 1'b0;
      hold_z = '0;
      check("ovf_flush", 64'(mac_if.ovf), 64'd0);
      tick(2);
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick(1);
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
